vcu_ctrl: RTL and testbench

Video control unit: the responder side of the CPU's VCU register port (control, wdata and rdata with per-register write strobes). It decodes commands written to the control register and queues data writes in a small FIFO. It drains that FIFO, or an internal clear sweep, into video memory over a valid/ready write port, and returns a live status word on rdata.

---
 rtl/vcu_pkg.sv | 32 +++
 rtl/vcu_fifo.sv | 62 ++++++
 rtl/vcu_ctrl.sv | 157 +++++++++++++++
 tb/tb_vcu_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vcu_pkg.sv
// Shared types and status-word layout for the video control unit.
// Imported by vcu_ctrl and vcu_fifo.
package vcu_pkg;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'd0,
        CMD_SET_ADDR = 2'd1,
        CMD_CLEAR    = 2'd2,
        CMD_ACK      = 2'd3
    } cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Bit positions inside the status word returned on vcu_reg_rdata
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_FRAME     = 3;
    localparam int STAT_AUTOINC   = 4;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_ADDR_LSB  = 16;

    // Bit positions inside the control register
    localparam int CTRL_ACK_OVF   = 2;
    localparam int CTRL_ACK_FRAME = 3;
    localparam int CTRL_AUTOINC   = 4;
    localparam int CTRL_ARG_LSB   = 8;

endpackage

// File: rtl/vcu_fifo.sv
// Synchronous write-queue FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Head data is read straight from storage.
module vcu_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             pushAccepted_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == LW'(DEPTH));
    assign level_o        = count_q;
    assign headData_o     = mem_q[rdPtr_q];
    assign doPop          = pop_i && !empty_o;
    assign doPush         = push_i && (!full_o || doPop);
    assign pushAccepted_o = doPush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + PW'(1);
        if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
        if (doPush && !doPop)      count_d = count_q + LW'(1);
        else if (!doPush && doPop) count_d = count_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only presented while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/vcu_ctrl.sv
// VCU register-port responder: decodes control commands, queues data writes and
// drains the queue (or a memory clear sweep) into video memory.
module vcu_ctrl
    import vcu_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       vcu_reg_control,
    input  logic              vcu_reg_control_we,
    input  logic [31:0]       vcu_reg_wdata,
    input  logic              vcu_reg_wdata_we,
    output logic [31:0]       vcu_reg_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              vram_we,
    input  logic              vram_ready,
    input  logic              frame_tick
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [ADDR_W-1:0] clrAddr_q, clrAddr_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              autoinc_q, autoinc_d;
    logic              overflow_q, overflow_d;
    logic              frame_q, frame_d;

    cmd_t              cmd;
    logic              isSetAddr, isClear, isAck;
    logic [ADDR_W-1:0] baseAddr;
    logic              baseAutoinc;

    logic [ENTRY_W-1:0] pushEntry, fifoHead;
    logic [ADDR_W-1:0]  headAddr;
    logic [DATA_W-1:0]  headData;
    logic               fifoPop, pushAccepted, fifoFull, fifoEmpty;
    logic [LW-1:0]      fifoLevel;
    logic               unusedBits;

    assign cmd        = cmd_t'(vcu_reg_control[1:0]);
    assign isSetAddr  = vcu_reg_control_we && (cmd == CMD_SET_ADDR);
    assign isClear    = vcu_reg_control_we && (cmd == CMD_CLEAR);
    assign isAck      = vcu_reg_control_we && (cmd == CMD_ACK);
    assign pushEntry  = {baseAddr, vcu_reg_wdata[DATA_W-1:0]};
    assign {headAddr, headData} = fifoHead;
    assign unusedBits = ^{vcu_reg_control, vcu_reg_wdata};

    vcu_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (vcu_reg_wdata_we),
        .pushData_i    (pushEntry),
        .pop_i         (fifoPop),
        .headData_o    (fifoHead),
        .pushAccepted_o(pushAccepted),
        .full_o        (fifoFull),
        .empty_o       (fifoEmpty),
        .level_o       (fifoLevel)
    );

    // A SET_ADDR in the same cycle as a push supplies that push's address and autoinc
    always_comb begin
        baseAddr    = wrAddr_q;
        baseAutoinc = autoinc_q;
        if (isSetAddr) begin
            baseAddr    = vcu_reg_control[CTRL_ARG_LSB +: ADDR_W];
            baseAutoinc = vcu_reg_control[CTRL_AUTOINC];
        end
        wrAddr_d  = baseAddr;
        autoinc_d = baseAutoinc;
        if (pushAccepted && baseAutoinc) wrAddr_d = baseAddr + ADDR_W'(1);

        overflow_d = overflow_q;
        frame_d    = frame_q;
        if (isAck && vcu_reg_control[CTRL_ACK_OVF])   overflow_d = 1'b0;
        if (isAck && vcu_reg_control[CTRL_ACK_FRAME]) frame_d    = 1'b0;
        if (vcu_reg_wdata_we && !pushAccepted)        overflow_d = 1'b1;
        if (frame_tick)                               frame_d    = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        fill_d    = fill_q;
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_data = '0;
        fifoPop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vram_we = !fifoEmpty;
                if (!fifoEmpty) begin
                    vram_addr = headAddr;
                    vram_data = headData;
                end
                fifoPop = !fifoEmpty && vram_ready;
                if (isClear) begin
                    state_d   = ST_CLEAR;
                    clrAddr_d = '0;
                    fill_d    = vcu_reg_control[CTRL_ARG_LSB +: DATA_W];
                end
            end
            ST_CLEAR: begin
                vram_we   = 1'b1;
                vram_addr = clrAddr_q;
                vram_data = fill_q;
                if (vram_ready) begin
                    clrAddr_d = clrAddr_q + ADDR_W'(1);
                    if (clrAddr_q == '1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wrAddr_q   <= '0;
            clrAddr_q  <= '0;
            fill_q     <= '0;
            autoinc_q  <= 1'b0;
            overflow_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrAddr_q   <= wrAddr_d;
            clrAddr_q  <= clrAddr_d;
            fill_q     <= fill_d;
            autoinc_q  <= autoinc_d;
            overflow_q <= overflow_d;
            frame_q    <= frame_d;
        end
    end

    always_comb begin
        vcu_reg_rdata                                = '0;
        vcu_reg_rdata[STAT_BUSY]                     = (state_q == ST_CLEAR) || !fifoEmpty;
        vcu_reg_rdata[STAT_FULL]                     = fifoFull;
        vcu_reg_rdata[STAT_OVF]                      = overflow_q;
        vcu_reg_rdata[STAT_FRAME]                    = frame_q;
        vcu_reg_rdata[STAT_AUTOINC]                  = autoinc_q;
        vcu_reg_rdata[STAT_LEVEL_LSB +: 8]           = 8'(fifoLevel);
        vcu_reg_rdata[STAT_ADDR_LSB +: ADDR_W]       = wrAddr_q;
    end

endmodule

// File: tb/tb_vcu_ctrl.sv
// Scoreboard bench for vcu_ctrl: directed register-port vectors push expected
// video-memory writes into a queue that a negedge monitor pops and compares.
module tb_vcu_ctrl;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic [31:0]       vcu_reg_control;
    logic              vcu_reg_control_we;
    logic [31:0]       vcu_reg_wdata;
    logic              vcu_reg_wdata_we;
    logic [31:0]       vcu_reg_rdata;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;
    logic              vram_we;
    logic              vram_ready;
    logic              frame_tick;

    int                assertCount = 0;
    int                failCount   = 0;
    logic [19:0]       expQ[$];
    logic              holdPending = 1'b0;
    logic [19:0]       holdVal     = '0;

    vcu_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .vcu_reg_control   (vcu_reg_control),
        .vcu_reg_control_we(vcu_reg_control_we),
        .vcu_reg_wdata     (vcu_reg_wdata),
        .vcu_reg_wdata_we  (vcu_reg_wdata_we),
        .vcu_reg_rdata     (vcu_reg_rdata),
        .vram_addr         (vram_addr),
        .vram_data         (vram_data),
        .vram_we           (vram_we),
        .vram_ready        (vram_ready),
        .frame_tick        (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one register-port cycle; returns just after the capturing edge
    task automatic applyStimulus(input logic [31:0] ctrl, input logic cwe, input logic [31:0] wd, input logic wwe);
        vcu_reg_control    = ctrl;
        vcu_reg_control_we = cwe;
        vcu_reg_wdata      = wd;
        vcu_reg_wdata_we   = wwe;
        @(posedge clk);
        #1;
        vcu_reg_control_we = 1'b0;
        vcu_reg_wdata_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input string name, input int limit, input bit randomReady);
        int cycles = 0;
        while (expQ.size() != 0 && cycles < limit) begin
            if (randomReady) vram_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cycles++;
        end
        vram_ready = 1'b1;
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Monitor: a handshake seen here completes on the following rising edge
    always @(negedge clk) begin
        logic [19:0] expEntry;
        if (!rst_n) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("holdWe", {31'b0, vram_we}, 32'd1);
                checkOutput("holdBus", {12'b0, vram_addr, vram_data}, {12'b0, holdVal});
            end
            if (vram_we && vram_ready) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%03h data 0x%02h, expected no write",
                             vram_addr, vram_data);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("vramWrite", {12'b0, vram_addr, vram_data}, {12'b0, expEntry});
                end
            end
            holdPending = vram_we && !vram_ready;
            holdVal     = {vram_addr, vram_data};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        vcu_reg_control    = '0;
        vcu_reg_control_we = 1'b0;
        vcu_reg_wdata      = '0;
        vcu_reg_wdata_we   = 1'b0;
        vram_ready         = 1'b0;
        frame_tick         = 1'b0;

        idle(3);
        checkOutput("resetRdata", vcu_reg_rdata, 32'h0000_0000);
        checkOutput("resetBus", {11'b0, vram_we, vram_addr, vram_data}, 32'h0);
        rst_n = 1'b1;
        idle(2);
        checkOutput("postResetRdata", vcu_reg_rdata, 32'h0000_0000);

        $display("[TB] sequential writes");
        vram_ready = 1'b1;
        applyStimulus(32'h0000_1011, 1'b1, 32'h0, 1'b0);
        checkOutput("setAddrStatus", vcu_reg_rdata, 32'h0010_0010);
        expQ.push_back({12'h010, 8'hA1});
        applyStimulus(32'h0, 1'b0, 32'h0000_00A1, 1'b1);
        checkOutput("pushLatency", {11'b0, vram_we, vram_addr, vram_data}, {11'b0, 1'b1, 12'h010, 8'hA1});
        expQ.push_back({12'h011, 8'hA2});
        applyStimulus(32'h0, 1'b0, 32'h0000_00A2, 1'b1);
        expQ.push_back({12'h012, 8'hA3});
        applyStimulus(32'h0, 1'b0, 32'h0000_00A3, 1'b1);
        waitDrain("seqDrain", 10, 1'b0);
        idle(2);
        checkOutput("seqStatus", vcu_reg_rdata, 32'h0013_0010);

        $display("[TB] overflow");
        vram_ready = 1'b0;
        applyStimulus(32'h0001_0011, 1'b1, 32'h0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) expQ.push_back({12'h100 + 12'(i - 1), 8'(i)});
            applyStimulus(32'h0, 1'b0, 32'(i), 1'b1);
        end
        checkOutput("ovfStatus", vcu_reg_rdata, 32'h0108_0817);
        applyStimulus(32'h0000_0007, 1'b1, 32'h0, 1'b0);
        checkOutput("ovfAck", vcu_reg_rdata, 32'h0108_0813);
        vram_ready = 1'b1;
        waitDrain("ovfDrain", 20, 1'b0);
        idle(2);
        checkOutput("ovfDrained", vcu_reg_rdata, 32'h0108_0010);

        $display("[TB] same-cycle command and push");
        expQ.push_back({12'h200, 8'h7E});
        applyStimulus(32'h0002_0001, 1'b1, 32'h0000_007E, 1'b1);
        waitDrain("sameDrain", 10, 1'b0);
        idle(2);
        checkOutput("sameStatus", vcu_reg_rdata, 32'h0200_0000);

        $display("[TB] frame flag");
        frame_tick = 1'b1;
        applyStimulus(32'h0000_000B, 1'b1, 32'h0, 1'b0);
        frame_tick = 1'b0;
        checkOutput("frameSetWins", vcu_reg_rdata, 32'h0200_0008);
        applyStimulus(32'h0000_0007, 1'b1, 32'h0, 1'b0);
        checkOutput("frameOvfAckOnly", vcu_reg_rdata, 32'h0200_0008);
        applyStimulus(32'h0000_000B, 1'b1, 32'h0, 1'b0);
        checkOutput("frameAcked", vcu_reg_rdata, 32'h0200_0000);

        $display("[TB] clear sweep");
        vram_ready = 1'b0;
        for (int i = 0; i < 4096; i++) expQ.push_back({12'(i), 8'h55});
        applyStimulus(32'h0000_5502, 1'b1, 32'h0, 1'b0);
        checkOutput("clearBusy", vcu_reg_rdata, 32'h0200_0001);
        expQ.push_back({12'h200, 8'h66});
        applyStimulus(32'h0, 1'b0, 32'h0000_0066, 1'b1);
        checkOutput("clearQueued", vcu_reg_rdata, 32'h0200_0101);
        waitDrain("clearDrain", 30000, 1'b1);
        idle(3);
        checkOutput("clearDone", vcu_reg_rdata, 32'h0200_0000);

        $display("[TB] reset mid-drain");
        vram_ready = 1'b0;
        applyStimulus(32'h0003_0011, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(32'h0, 1'b0, 32'h0000_00C0 + 32'(i), 1'b1);
        checkOutput("preResetStatus", vcu_reg_rdata, 32'h0305_0511);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetWe", {31'b0, vram_we}, 32'd0);
        checkOutput("midResetRdata", vcu_reg_rdata, 32'h0000_0000);
        idle(2);
        rst_n      = 1'b1;
        vram_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput("noStaleWe", {31'b0, vram_we}, 32'd0);
        end
        checkOutput("afterResetRdata", vcu_reg_rdata, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
